// File: rtl/decomp_pkg.sv
// Shared types for the decompressor front end: word type, sequential step,
// and the prefetch classification of the requested PC against the stream.
package decomp_pkg;

   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   localparam word_t PCADD = 32'h4;

   typedef enum logic [1:0] {
      HIT,
      ADVANCE,
      FLUSH
   } pf_class_e;

   // ADVANCE only makes sense when there is a head word to pop.
   function automatic pf_class_e pf_classify(input logic at_exp,
                                             input logic at_next,
                                             input logic nonempty);
      if (at_exp) begin
         return HIT;
      end else if (at_next && nonempty) begin
         return ADVANCE;
      end else begin
         return FLUSH;
      end
   endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// In-order circular queue of {addr, data} entries with push, pop and a
// whole-queue clear; head and occupancy are presented from registers.
module prefetch_fifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  logic [DW-1:0]            wdata,
   output logic [DW-1:0]            head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DW-1:0] store [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear) begin
         store[wr_ptr] <= wdata;
      end
   end

   assign head = store[rd_ptr];

endmodule

// File: rtl/imem_prefetch_buffer.sv
// Instruction prefetch buffer: runs ahead of the decompressor fetch PC,
// queues returned words in order and refetches when the PC leaves the stream.
module imem_prefetch_buffer #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] PCADD    = WIDTH'(decomp_pkg::PCADD),
   parameter int               DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] PCcompress,
   output logic [WIDTH-1:0] NextInstr,
   output logic             instr_valid,
   output logic             mem_req,
   output logic [WIDTH-1:0] mem_addr,
   input  logic             mem_ready,
   input  logic             mem_rvalid,
   input  logic [WIDTH-1:0] mem_rdata
);

   import decomp_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;

   logic [CW-1:0]      occ;
   logic [CW-1:0]      live_out;
   logic [CW-1:0]      drop_cnt;
   logic [WIDTH-1:0]   exp_addr;
   logic [WIDTH-1:0]   fetch_addr;
   logic [WIDTH-1:0]   push_addr;
   logic [WIDTH-1:0]   head_addr;
   logic [WIDTH-1:0]   head_data;
   logic [2*WIDTH-1:0] head_entry;
   logic [CW+1:0]      credit_used;
   pf_class_e          cls;
   logic               is_adv;
   logic               is_flush;
   logic               accept;
   logic               resp_drop;
   logic               resp_live;
   logic               push;

   always_comb begin
      cls = pf_classify(PCcompress == exp_addr,
                        PCcompress == exp_addr + PCADD,
                        occ != '0);
   end

   assign is_adv   = (cls == ADVANCE);
   assign is_flush = (cls == FLUSH);

   assign head_addr = head_entry[2*WIDTH-1:WIDTH];
   assign head_data = head_entry[WIDTH-1:0];

   // The head entry always sits at exp_addr, so a tag match is exactly a HIT with data present.
   assign instr_valid = (occ != '0) && (head_addr == PCcompress);
   assign NextInstr   = instr_valid ? head_data : '0;

   // Every slot is reserved at issue, so queued, outstanding and stale
   // fetches together never exceed the queue.
   assign credit_used = (CW+2)'(occ) + (CW+2)'(live_out) + (CW+2)'(drop_cnt);
   assign mem_req     = reset && !is_flush && (credit_used < (CW+2)'(DEPTH));
   assign mem_addr    = fetch_addr;
   assign accept      = mem_req && mem_ready;

   assign resp_drop = mem_rvalid && (drop_cnt != '0);
   assign resp_live = mem_rvalid && (drop_cnt == '0);
   assign push      = resp_live && !is_flush;

   // The tail address does not move when the head pops, because exp_addr advances by the same step.
   assign push_addr = exp_addr + WIDTH'(occ) * PCADD;

   prefetch_fifo #(
      .DEPTH (DEPTH),
      .DW    (2*WIDTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (is_adv),
      .clear (is_flush),
      .wdata ({push_addr, mem_rdata}),
      .head  (head_entry),
      .count (occ)
   );

   // On a flush, everything still in flight becomes stale and is drained before any new response is kept.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         exp_addr   <= RESET_PC;
         fetch_addr <= RESET_PC;
         live_out   <= '0;
         drop_cnt   <= '0;
      end else if (is_flush) begin
         exp_addr   <= PCcompress;
         fetch_addr <= PCcompress;
         live_out   <= '0;
         drop_cnt   <= drop_cnt + live_out - CW'(resp_live) - CW'(resp_drop);
      end else begin
         if (is_adv) begin
            exp_addr <= exp_addr + PCADD;
         end
         if (accept) begin
            fetch_addr <= fetch_addr + PCADD;
         end
         live_out <= live_out + CW'(accept) - CW'(push);
         drop_cnt <= drop_cnt - CW'(resp_drop);
      end
   end

endmodule
